// File: rtl/reconf_fir_seq_pkg.sv
// Shared types and helpers for the self-sequenced reconfigurable FIR filter.
package reconf_fir_seq_pkg;

    // Sequencer states: wait for a strobe, walk the taps, flush the pipe, publish.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fir_state_e;

    // Accumulator width: full product plus enough guard bits for NTAP terms.
    function automatic int acc_width(input int din_w, input int coef_w, input int ntap);
        return din_w + coef_w + $clog2(ntap);
    endfunction

    // Clamp a signed value into the out_w-bit two's complement range.
    function automatic longint sat_clamp(input longint v, input int out_w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (out_w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // High when sat_clamp would alter the value.
    function automatic logic sat_hit(input longint v, input int out_w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (out_w - 1)) - 1;
        lo = -hi - 1;
        return (v > hi) || (v < lo);
    endfunction

endpackage

// File: rtl/reconf_fir_seq_coef_ram.sv
// Coefficient store: NTAP words, synchronous write, combinational read,
// asynchronous clear. Addresses at or beyond NTAP are ignored on write and
// read back as zero.
module fir_coef_ram #(
    parameter int NTAP   = 10,
    parameter int COEF_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [COEF_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [COEF_W-1:0] rdata_o
);

    logic [COEF_W-1:0] mem_q [NTAP];

    // Clear every word on reset; otherwise write the addressed word when enabled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NTAP; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            for (int i = 0; i < NTAP; i++)
                if (waddr_i == ADDR_W'(i)) mem_q[i] <= wdata_i;
        end
    end

    // Decode the read address; out-of-range reads return zero.
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < NTAP; i++)
            if (raddr_i == ADDR_W'(i)) rdata_o = mem_q[i];
    end

endmodule

// File: rtl/reconf_fir_seq.sv
// Self-sequenced reconfigurable FIR: each accepted sample strobe launches a
// tap-serial multiply-accumulate through a three-stage pipeline, then the
// result is shifted, saturated and published with a one-cycle valid pulse.
module reconf_fir_seq
    import reconf_fir_seq_pkg::*;
#(
    parameter int NTAP      = 10,
    parameter int DIN_W     = 3,
    parameter int COEF_W    = 16,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 0,
    parameter int ADDR_W    = 6
) (
    input  logic              iClk12M,
    input  logic              iRst,
    input  logic              iEnSample600k,
    input  logic [DIN_W-1:0]  iFirIn,
    input  logic              iCoeffUpdateFlag,
    input  logic              iCsnRam,
    input  logic              iWrnRam,
    input  logic [ADDR_W-1:0] iAddrRam,
    input  logic [COEF_W-1:0] iWtDtRam,
    output logic [OUT_W-1:0]  oFirOut,
    output logic              oValid,
    output logic              oBusy,
    output logic              oSat,
    output logic              oOverrun
);

    localparam int ACC_W  = acc_width(DIN_W, COEF_W, NTAP);
    localparam int PROD_W = DIN_W + COEF_W;
    localparam int TAP_W  = $clog2(NTAP);

    fir_state_e          state_q, state_d;
    logic [TAP_W-1:0]    tap_q, tap_d;
    logic                drain_q, drain_d;
    logic                start;

    logic signed [DIN_W-1:0]  x_q [NTAP];
    logic signed [DIN_W-1:0]  x_sel;
    logic [COEF_W-1:0]        coef_rd;

    logic                     vld_p1, vld_p2;
    logic signed [COEF_W-1:0] coef_p1;
    logic signed [DIN_W-1:0]  x_p1;
    logic signed [PROD_W-1:0] prod_p2;
    logic signed [ACC_W-1:0]  acc_p3;
    logic signed [ACC_W-1:0]  acc_sh;

    assign start  = iEnSample600k && !iCoeffUpdateFlag && (state_q == ST_IDLE);
    assign oBusy  = (state_q != ST_IDLE);
    assign acc_sh = acc_p3 >>> OUT_SHIFT;

    fir_coef_ram #(
        .NTAP   (NTAP),
        .COEF_W (COEF_W),
        .ADDR_W (ADDR_W)
    ) u_coef_ram (
        .clk_i   (iClk12M),
        .rst_i   (iRst),
        .we_i    (iCoeffUpdateFlag && !iCsnRam && !iWrnRam),
        .waddr_i (iAddrRam),
        .wdata_i (iWtDtRam),
        .raddr_i (ADDR_W'(tap_q)),
        .rdata_o (coef_rd)
    );

    // Shift a new sample in only when the sequencer is idle; busy strobes are dropped.
    always_ff @(posedge iClk12M or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < NTAP; i++) x_q[i] <= '0;
        end else if (iEnSample600k && state_q == ST_IDLE) begin
            x_q[0] <= $signed(iFirIn);
            for (int i = 1; i < NTAP; i++) x_q[i] <= x_q[i-1];
        end
    end

    // Select the delay-line tap that pairs with the coefficient being read.
    always_comb begin
        x_sel = '0;
        for (int i = 0; i < NTAP; i++)
            if (tap_q == TAP_W'(i)) x_sel = x_q[i];
    end

    // Sequencer state register.
    always_ff @(posedge iClk12M or posedge iRst) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            tap_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            drain_q <= drain_d;
        end
    end

    // Next-state logic: RUN walks taps 0..NTAP-1, DRAIN waits out the two pipe stages.
    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    tap_d   = '0;
                end
            end
            ST_RUN: begin
                if (tap_q == TAP_W'(NTAP - 1)) begin
                    state_d = ST_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q) state_d = ST_DONE;
                else         drain_d = 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Pipeline valids and output control flags.
    always_ff @(posedge iClk12M or posedge iRst) begin
        if (iRst) begin
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            oValid   <= 1'b0;
            oFirOut  <= '0;
            oSat     <= 1'b0;
            oOverrun <= 1'b0;
        end else begin
            vld_p1 <= (state_q == ST_RUN);
            vld_p2 <= vld_p1;
            oValid <= (state_q == ST_DONE);
            if (state_q == ST_DONE) begin
                oFirOut <= OUT_W'(sat_clamp(longint'(acc_sh), OUT_W));
                oSat    <= sat_hit(longint'(acc_sh), OUT_W);
            end
            if (iEnSample600k && state_q != ST_IDLE) oOverrun <= 1'b1;
        end
    end

    // MAC datapath; no reset needed since the accumulator clears on every run start.
    always_ff @(posedge iClk12M) begin
        // stage 1: operand capture
        coef_p1 <= $signed(coef_rd);
        x_p1    <= x_sel;
        // stage 2: product
        prod_p2 <= PROD_W'(x_p1) * PROD_W'(coef_p1);
        // stage 3: accumulate
        if (start)       acc_p3 <= '0;
        else if (vld_p2) acc_p3 <= acc_p3 + ACC_W'(prod_p2);
    end

endmodule

// File: tb/tb_reconf_fir_seq.sv
// Scoreboard bench for reconf_fir_seq: a behavioural model predicts each
// filter output when a strobe is accepted; the monitor pops and compares.
module tb_reconf_fir_seq;

    localparam int NTAP      = 10;
    localparam int DIN_W     = 3;
    localparam int COEF_W    = 16;
    localparam int OUT_W     = 16;
    localparam int OUT_SHIFT = 0;
    localparam int ADDR_W    = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              iEnSample600k;
    logic [DIN_W-1:0]  iFirIn;
    logic              iCoeffUpdateFlag;
    logic              iCsnRam;
    logic              iWrnRam;
    logic [ADDR_W-1:0] iAddrRam;
    logic [COEF_W-1:0] iWtDtRam;
    logic [OUT_W-1:0]  oFirOut;
    logic              oValid;
    logic              oBusy;
    logic              oSat;
    logic              oOverrun;

    always #5 clk = ~clk;

    reconf_fir_seq #(
        .NTAP(NTAP), .DIN_W(DIN_W), .COEF_W(COEF_W),
        .OUT_W(OUT_W), .OUT_SHIFT(OUT_SHIFT), .ADDR_W(ADDR_W)
    ) dut (
        .iClk12M          (clk),
        .iRst             (rst),
        .iEnSample600k    (iEnSample600k),
        .iFirIn           (iFirIn),
        .iCoeffUpdateFlag (iCoeffUpdateFlag),
        .iCsnRam          (iCsnRam),
        .iWrnRam          (iWrnRam),
        .iAddrRam         (iAddrRam),
        .iWtDtRam         (iWtDtRam),
        .oFirOut          (oFirOut),
        .oValid           (oValid),
        .oBusy            (oBusy),
        .oSat             (oSat),
        .oOverrun         (oOverrun)
    );

    typedef struct {
        int out;
        bit sat;
        int due;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_valid = 0;
    int   vld_cyc = 0;
    int   last_acc = -1000;
    bit   exp_ovr  = 1'b0;
    exp_t sb[$];
    int   mx[NTAP];
    int   mc[NTAP];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int due);
        exp_t   e;
        longint acc;
        longint hi;
        longint lo;
        acc = 0;
        for (int k = 0; k < NTAP; k++) acc += longint'(mx[k]) * longint'(mc[k]);
        acc = acc >>> OUT_SHIFT;
        hi  = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo  = -hi - 1;
        e.sat = (acc > hi) || (acc < lo);
        e.out = (acc > hi) ? int'(hi) : (acc < lo) ? int'(lo) : int'(acc);
        e.due = due;
        return e;
    endfunction

    // Monitor: compare every published result against the scoreboard head.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && oValid) begin
            n_valid++;
            vld_cyc = cyc;
            if (sb.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out", $signed(oFirOut), e.out);
                check("sat", oSat, e.sat);
                check("latency", cyc, e.due);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [COEF_W-1:0] d);
        iCsnRam  = 1'b0;
        iWrnRam  = 1'b0;
        iAddrRam = a;
        iWtDtRam = d;
        @(posedge clk);
        #1;
        if (iCoeffUpdateFlag && a < NTAP) mc[a] = $signed(d);
        iCsnRam = 1'b1;
        iWrnRam = 1'b1;
    endtask

    task automatic load_coefs(input logic [COEF_W-1:0] base, input bit ramp);
        iCoeffUpdateFlag = 1'b1;
        for (int k = 0; k < NTAP; k++)
            wr(ADDR_W'(k), ramp ? COEF_W'(base + COEF_W'(k)) : base);
        iCoeffUpdateFlag = 1'b0;
    endtask

    task automatic strobe(input logic [DIN_W-1:0] x);
        iEnSample600k = 1'b1;
        iFirIn        = x;
        @(posedge clk);
        #1;
        iEnSample600k = 1'b0;
        if ((cyc - last_acc) < NTAP + 4) begin
            exp_ovr = 1'b1;
        end else begin
            for (int k = NTAP - 1; k > 0; k--) mx[k] = mx[k-1];
            mx[0] = $signed(x);
            if (!iCoeffUpdateFlag) begin
                last_acc = cyc;
                sb.push_back(model(cyc + NTAP + 3));
            end
        end
    endtask

    task automatic sample(input logic [DIN_W-1:0] x);
        strobe(x);
        tick(19);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NTAP; k++) begin
            mx[k] = 0;
            mc[k] = 0;
        end
        sb.delete();
        last_acc = -1000;
        exp_ovr  = 1'b0;
    endtask

    initial begin : stim
        int strobe_cyc;
        int nv;
        rst = 1'b1;
        iEnSample600k = 1'b0;
        iFirIn = '0;
        iCoeffUpdateFlag = 1'b0;
        iCsnRam = 1'b1;
        iWrnRam = 1'b1;
        iAddrRam = '0;
        iWtDtRam = '0;
        model_reset();
        tick(3);
        check("rst_out", oFirOut, 0);
        check("rst_valid", oValid, 0);
        check("rst_busy", oBusy, 0);
        check("rst_sat", oSat, 0);
        check("rst_ovr", oOverrun, 0);
        rst = 1'b0;
        tick(2);

        // write attempt while not in update mode must be ignored
        wr(ADDR_W'(0), 16'h1234);
        load_coefs(16'h0A00, 1'b1);

        // 1: impulse response
        strobe(3'b001);
        tick(2);
        check("busy_run", oBusy, 1);
        tick(17);
        for (int i = 0; i < 10; i++) sample(3'b000);
        check("ovr_none", oOverrun, exp_ovr);

        // 2: negative impulse and latency
        strobe(3'b111);
        strobe_cyc = cyc;
        tick(19);
        check("lat14", vld_cyc - strobe_cyc + 1, NTAP + 4);
        check("neg_first", $signed(oFirOut), -2560);
        for (int i = 0; i < 10; i++) sample(3'b000);

        // 3: saturation both ways
        load_coefs(16'h7FFF, 1'b0);
        for (int i = 0; i < 10; i++) sample(3'b011);
        check("sat_pos", oFirOut, 16'h7FFF);
        for (int i = 0; i < 12; i++) sample(3'b100);
        check("sat_neg", oFirOut, 16'h8000);
        check("sat_flag", oSat, 1);

        // 4: overrun while busy
        load_coefs(16'h0A00, 1'b1);
        for (int i = 0; i < 10; i++) sample(3'b000);
        check("ovr_pre", oOverrun, 0);
        strobe(3'b001);
        tick(4);
        strobe(3'b011);
        tick(14);
        check("ovr_set", oOverrun, exp_ovr);
        for (int i = 0; i < 10; i++) sample(3'b000);

        // 5: update mode inhibits runs; out-of-range address ignored
        iCoeffUpdateFlag = 1'b1;
        wr(ADDR_W'(3), 16'h0001);
        wr(ADDR_W'(12), 16'hFFFF);
        nv = n_valid;
        strobe(3'b000);
        tick(19);
        check("upd_novalid", n_valid, nv);
        iCoeffUpdateFlag = 1'b0;
        for (int i = 0; i < 3; i++) sample(i == 0 ? 3'b001 : 3'b000);
        strobe(3'b000);
        tick(19);
        check("upd_tap3", oFirOut, 16'h0001);
        for (int i = 0; i < 7; i++) sample(3'b000);

        // 6: asynchronous reset mid-run
        strobe(3'b001);
        tick(6);
        rst = 1'b1;
        #1;
        model_reset();
        check("mid_out", oFirOut, 0);
        check("mid_valid", oValid, 0);
        check("mid_busy", oBusy, 0);
        check("mid_ovr", oOverrun, 0);
        tick(2);
        rst = 1'b0;
        nv = n_valid;
        tick(20);
        check("mid_novalid", n_valid, nv);
        load_coefs(16'h0A00, 1'b1);
        sample(3'b001);
        sample(3'b000);
        sample(3'b000);
        check("post_rst", oFirOut, 16'h0A02);

        tick(20);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
